// File: rtl/usb_dfu_flash_sequencer.sv
// usb_dfu_flash_sequencer: turns one DFU DNLOAD/UPLOAD block command into a
// series of per-page SPI flash bridge transactions. It drives the page address
// and the rd/wr request lines, counts byte strobes, waits out program busy and
// reports done + status. Byte data flows between the endpoint FIFOs and the
// bridge without passing through here.
// Optional build macro USB_FLASH_SEQ_TIMEOUT_EN adds a watchdog on flash_wr_busy
// that ends the command with ERR_PROG after TIMEOUT_CYCLES busy cycles.
module usb_dfu_flash_sequencer #(
  parameter int unsigned PAGE_SIZE       = 256,
  parameter int unsigned PAGES_PER_BLOCK = 4,
  parameter logic [15:0] BASE_PAGE       = 16'h0200,
  parameter logic [15:0] MAX_PAGES       = 16'h0E00,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd12000000,
  localparam int unsigned BLOCK_BYTES    = PAGES_PER_BLOCK * PAGE_SIZE,
  localparam int unsigned LEN_W          = $clog2(BLOCK_BYTES) + 1,
  localparam int unsigned PIDX_W         = $clog2(PAGES_PER_BLOCK) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_block,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic             done,
  output logic [1:0]       status,
  output logic             busy,
  output logic [15:0]      flash_address,
  output logic             flash_rd_request,
  output logic             flash_wr_request,
  input  logic             flash_rd_data_put,
  input  logic             flash_wr_data_get,
  input  logic             flash_wr_busy
);

  localparam int unsigned PG_SH  = $clog2(PAGE_SIZE);
  localparam int unsigned PPB_SH = $clog2(PAGES_PER_BLOCK);

  // Non-power-of-2 geometry would break the shift-based page math.
  if (((PAGE_SIZE & (PAGE_SIZE - 1)) != 0) ||
      ((PAGES_PER_BLOCK & (PAGES_PER_BLOCK - 1)) != 0) ||
      (TIMEOUT_CYCLES == 24'd0)) begin : g_bad_cfg
    $error("usb_dfu_flash_sequencer: invalid geometry or timeout parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_GAP, S_WR_STREAM, S_WR_WAIT, S_RD_STREAM, S_ABORT_WAIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {ST_OK, ST_ERR_ADDR, ST_ERR_PROG, ST_ABORTED} status_e;

  state_e             state_q;
  status_e            status_q;
  logic               ready_q, busy_q, done_q, rd_q, wr_q, write_q, gap_q, seen_q;
  logic [15:0]        block_q, addr_q;
  logic [LEN_W-1:0]   len_q, rem_q, cnt_q;
  logic [PIDX_W-1:0]  idx_q;
  logic [1:0]         wait_q;
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
  logic [23:0]        tmo_q;
`endif

  logic [31:0]        len32_d, first_d, npages_d, addr_base_d;
  logic [LEN_W-1:0]   page_bytes_d, cnt_d, rem_d;
  logic [PIDX_W-1:0]  idx_d;
  logic [15:0]        addr_d;
  logic               strobe_d, page_end_d, range_err_d;

  // Page geometry and per-page byte accounting derived from latched fields.
  always_comb begin
    len32_d      = 32'(len_q);
    first_d      = 32'(block_q) << PPB_SH;
    npages_d     = (len32_d + 32'(PAGE_SIZE) - 32'd1) >> PG_SH;
    range_err_d  = (len32_d > 32'(BLOCK_BYTES)) || ((first_d + npages_d) > 32'(MAX_PAGES));
    addr_base_d  = 32'(BASE_PAGE) + first_d;
    page_bytes_d = (rem_q > LEN_W'(PAGE_SIZE)) ? LEN_W'(PAGE_SIZE) : rem_q;
    strobe_d     = (state_q == S_WR_STREAM) ? flash_wr_data_get : flash_rd_data_put;
    cnt_d        = cnt_q + LEN_W'(strobe_d);
    page_end_d   = (cnt_d == page_bytes_d);
    rem_d        = rem_q - page_bytes_d;
    idx_d        = idx_q + PIDX_W'(1);
    addr_d       = 16'(addr_base_d + 32'(idx_d));
  end

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  status_q <= ST_OK;
      ready_q <= 1'b0;    busy_q   <= 1'b0;  done_q <= 1'b0;
      rd_q    <= 1'b0;    wr_q     <= 1'b0;  write_q <= 1'b0;
      gap_q   <= 1'b0;    seen_q   <= 1'b0;  wait_q <= '0;
      block_q <= '0;      addr_q   <= '0;    len_q  <= '0;
      rem_q   <= '0;      cnt_q    <= '0;    idx_q  <= '0;
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            write_q <= cmd_write;
            block_q <= cmd_block;
            len_q   <= cmd_len;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        // A program in flight is never cut short; wait for the bridge to go idle.
        S_ABORT_WAIT: begin
          if (!flash_wr_busy) begin
            state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_ABORTED;
          end
        end
        default: begin
          if (cmd_abort) begin
            // Abort wins over a page completing in the same cycle.
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (write_q) state_q <= S_ABORT_WAIT;
            else begin
              state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_ABORTED;
            end
          end else begin
            case (state_q)
              S_CHECK: begin
                if (range_err_d) begin
                  state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_ERR_ADDR;
                end else if (len_q == '0) begin
                  state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_OK;
                end else begin
                  idx_q   <= '0;
                  rem_q   <= len_q;
                  cnt_q   <= '0;
                  addr_q  <= 16'(addr_base_d);
                  gap_q   <= 1'b0;
                  state_q <= S_GAP;
                end
              end
              // Two quiet cycles so the bridge sees a clean request rising edge.
              S_GAP: begin
                if (gap_q) begin
                  gap_q <= 1'b0;
                  if (write_q) begin wr_q <= 1'b1; state_q <= S_WR_STREAM; end
                  else         begin rd_q <= 1'b1; state_q <= S_RD_STREAM; end
                end else begin
                  gap_q <= 1'b1;
                end
              end
              S_WR_STREAM: begin
                cnt_q <= cnt_d;
                if (page_end_d) begin
                  wr_q    <= 1'b0;
                  wait_q  <= '0;
                  seen_q  <= 1'b0;
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
                  state_q <= S_WR_WAIT;
                end
              end
              // Busy must rise then fall; four quiet cycles count as a missed pulse.
              S_WR_WAIT: begin
                if (flash_wr_busy) seen_q <= 1'b1;
                if (wait_q != 2'd3) wait_q <= wait_q + 2'd1;
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
                if (flash_wr_busy) tmo_q <= tmo_q + 24'd1;
`endif
                if (!flash_wr_busy && (seen_q || wait_q == 2'd3)) begin
                  rem_q <= rem_d; idx_q <= idx_d; cnt_q <= '0;
                  if (rem_d == '0) begin
                    state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_OK;
                  end else begin
                    addr_q <= addr_d; gap_q <= 1'b0; state_q <= S_GAP;
                  end
                end
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
                else if (flash_wr_busy && tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                  state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_ERR_PROG;
                end
`endif
              end
              S_RD_STREAM: begin
                cnt_q <= cnt_d;
                if (page_end_d) begin
                  rd_q  <= 1'b0;
                  rem_q <= rem_d; idx_q <= idx_d; cnt_q <= '0;
                  if (rem_d == '0) begin
                    state_q <= S_DONE; done_q <= 1'b1; status_q <= ST_OK;
                  end else begin
                    addr_q <= addr_d; gap_q <= 1'b0; state_q <= S_GAP;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready        = ready_q;
  assign done             = done_q;
  assign status           = status_q;
  assign busy             = busy_q;
  assign flash_address    = addr_q;
  assign flash_rd_request = rd_q;
  assign flash_wr_request = wr_q;

endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// tb_usb_dfu_flash_sequencer: randomized bench acting as the SPI flash bridge.
// Expected page lists and status codes come from a block-level model of the
// DFU-to-page mapping; directed sequences cover abort, stuck busy and reset.
module tb_usb_dfu_flash_sequencer;
  localparam int LEN_W = 11;

  logic             clk = 1'b0, reset = 1'b0;
  logic             cmd_valid = 1'b0, cmd_write = 1'b0, cmd_abort = 1'b0;
  logic [15:0]      cmd_block = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready, done, busy, flash_rd_request, flash_wr_request;
  logic [1:0]       status;
  logic [15:0]      flash_address;
  logic             flash_rd_data_put = 1'b0, flash_wr_data_get = 1'b0, flash_wr_busy = 1'b0;

  always #5 clk = ~clk;

  usb_dfu_flash_sequencer #(
    .PAGE_SIZE(256), .PAGES_PER_BLOCK(4), .BASE_PAGE(16'h0200),
    .MAX_PAGES(16'h0E00), .TIMEOUT_CYCLES(24'd1000)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_block(cmd_block), .cmd_len(cmd_len),
    .cmd_abort(cmd_abort), .done(done), .status(status), .busy(busy),
    .flash_address(flash_address), .flash_rd_request(flash_rd_request),
    .flash_wr_request(flash_wr_request), .flash_rd_data_put(flash_rd_data_put),
    .flash_wr_data_get(flash_wr_data_get), .flash_wr_busy(flash_wr_busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct { logic [15:0] addr; int bytes; } page_t;
  page_t exp_q[$];
  int    exp_status;

  // Block-level reference: which pages a command touches and how it ends.
  task automatic model(input int blk, input int len);
    int first, np;
    first = blk * 4;
    np    = (len + 255) / 256;
    exp_q.delete();
    if (len > 1024 || first + np > 'hE00) exp_status = 1;
    else begin
      exp_status = 0;
      for (int i = 0; i < np; i++) begin
        page_t p;
        p.addr  = 16'(32'h200 + first + i);
        p.bytes = (len - 256 * i > 256) ? 256 : len - 256 * i;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit w, input int blk, input int len);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin step(); t++; end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_block = 16'(blk); cmd_len = LEN_W'(len);
    step();
    cmd_valid = 1'b0;
    chk("cmd_ready_drops", cmd_ready, 0);
  endtask

  // Full command with the bench standing in for the bridge.
  task automatic run_cmd(input bit w, input int blk, input int len);
    int cyc, lowcnt, bytes, bdly, blen;
    bit prev_req, req_now, s, fin;
    page_t cur;
    model(blk, len);
    issue(w, blk, len);
    cyc = 0; lowcnt = 0; bytes = 0; bdly = 0; blen = 0; prev_req = 0; fin = 0;
    cur.addr = '0; cur.bytes = 0;
    while (cyc < 5000 && !fin) begin
      req_now = flash_rd_request | flash_wr_request;
      if (req_now && !prev_req) begin
        chk("gap_before_page", (lowcnt >= 2), 1);
        if (exp_q.size() == 0) chk("unexpected_page", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("page_addr", flash_address, cur.addr);
          chk("page_is_write", flash_wr_request, w);
        end
        bytes = 0;
      end
      if (!req_now && prev_req) begin
        chk("page_bytes", bytes, cur.bytes);
        if (w) begin
          if ($urandom_range(0, 3) == 0) begin bdly = 0; blen = 0; end
          else begin bdly = $urandom_range(0, 2); blen = $urandom_range(1, 8); end
        end
      end
      if (done) begin
        chk("done_status", status, exp_status);
        chk("pages_left", exp_q.size(), 0);
        chk("busy_with_done", busy, 1);
        if (exp_status == 1) chk("err_latency", (cyc <= 3), 1);
        fin = 1;
      end else begin
        lowcnt = req_now ? 0 : lowcnt + 1;
        s = ($urandom_range(0, 3) != 0);
        if (req_now) begin
          flash_wr_data_get = flash_wr_request & s;
          flash_rd_data_put = flash_rd_request & s;
          bytes += int'(s);
        end else begin
          flash_wr_data_get = ($urandom_range(0, 7) == 0);
          flash_rd_data_put = ($urandom_range(0, 7) == 0);
        end
        if (bdly > 0) begin bdly--; flash_wr_busy = 1'b0; end
        else if (blen > 0) begin blen--; flash_wr_busy = 1'b1; end
        else flash_wr_busy = 1'b0;
        prev_req = req_now;
        step();
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    flash_wr_data_get = 0; flash_rd_data_put = 0; flash_wr_busy = 0;
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_not_busy", busy, 0);
  endtask

  task automatic wait_req(input string tag);
    int t;
    t = 0;
    while (!(flash_rd_request | flash_wr_request) && t < 20) begin step(); t++; end
    chk(tag, (flash_rd_request | flash_wr_request), 1);
  endtask

  initial begin
    int  n, t;
    bit  early;
    // Reset state
    repeat (3) step();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", flash_address, 0);
    chk("rst_reqs", {flash_rd_request, flash_wr_request}, 0);
    @(negedge clk) reset = 1'b1;
    step();
    chk("ready_after_reset", cmd_ready, 1);

    // Directed plan items and address-range boundaries
    run_cmd(1, 3, 1024);
    run_cmd(0, 0, 300);
    run_cmd(1, 'h380, 256);
    run_cmd(1, 'h380, 0);
    run_cmd(0, 5, 0);
    run_cmd(1, 'h37F, 1024);
    run_cmd(0, 2, 1025);
    run_cmd(0, 'hFFFF, 10);
    run_cmd(0, 7, 1);
    run_cmd(1, 9, 257);

    // Randomized commands
    for (int i = 0; i < 16; i++) begin
      int blk, len, sel;
      blk = ($urandom_range(0, 7) == 0) ? $urandom_range('h37D, 'h400) : $urandom_range(0, 'h37F);
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1025, 1100) :
            (sel == 2) ? 256 : $urandom_range(1, 1024);
      run_cmd($urandom_range(0, 1) == 1, blk, len);
    end

    // Abort mid-write with program busy held for 50 cycles
    issue(1, 1, 1024);
    wait_req("abort_req_seen");
    chk("abort_addr", flash_address, 16'h0204);
    flash_wr_data_get = 1'b1;
    repeat (100) step();
    flash_wr_data_get = 1'b0; cmd_abort = 1'b1; flash_wr_busy = 1'b1;
    step();
    chk("abort_req_drop", flash_wr_request, 0);
    cmd_abort = 1'b0;
    early = 0;
    repeat (49) begin if (done) early = 1; step(); end
    chk("abort_no_early_done", early, 0);
    flash_wr_busy = 1'b0;
    t = 0;
    while (!done && t < 10) begin step(); t++; end
    chk("abort_done", done, 1);
    chk("abort_status", status, 3);
    step();

    // Program busy stuck high
    issue(1, 2, 10);
    wait_req("stuck_req_seen");
    flash_wr_data_get = 1'b1;
    repeat (10) step();
    flash_wr_data_get = 1'b0;
    chk("stuck_req_low", flash_wr_request, 0);
    flash_wr_busy = 1'b1;
    n = 0;
    while (!done && n < 1200) begin step(); n++; end
`ifdef USB_FLASH_SEQ_TIMEOUT_EN
    chk("tmo_done", done, 1);
    chk("tmo_status", status, 2);
    chk("tmo_cycles", (n >= 990 && n <= 1010), 1);
    flash_wr_busy = 1'b0;
    step();
`else
    chk("stuck_no_done", done, 0);
    chk("stuck_busy", busy, 1);
    flash_wr_busy = 1'b0;
    t = 0;
    while (!done && t < 10) begin step(); t++; end
    chk("stuck_release_done", done, 1);
    chk("stuck_release_status", status, 0);
    step();
`endif

    // Reset in the middle of a read page
    issue(0, 5, 512);
    wait_req("rst_mid_req_seen");
    flash_rd_data_put = 1'b1;
    repeat (20) step();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rd_req", flash_rd_request, 0);
    chk("rst_mid_busy", busy, 0);
    flash_rd_data_put = 1'b0;
    early = 0;
    repeat (3) begin if (done) early = 1; step(); end
    chk("rst_mid_no_done", early, 0);
    @(negedge clk) reset = 1'b1;
    step();
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_done_low", done, 0);
    run_cmd(0, 5, 512);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
